// File: rtl/regfile_multiport_if.sv
// Bus bundle for regfile_multiport: WB write port, registered read ports,
// combinational debug read and the clear-sweep handshake.
interface regfile_multiport_if #(
   parameter int WIDTH  = 32,
   parameter int DEPTH  = 32,
   parameter int NB     = $clog2(DEPTH),
   parameter int NUM_RD = 2
);
   logic                    RegWrite;
   logic [NB-1:0]           write_register;
   logic [WIDTH-1:0]        write_data;
   logic [NUM_RD*NB-1:0]    read_register;
   logic [NUM_RD*WIDTH-1:0] read_data;
   logic [NB-1:0]           debug_addr;
   logic [WIDTH-1:0]        debug_data;
   logic                    clear_start;
   logic                    clear_busy;
   logic                    clear_done;

   modport master (
      output RegWrite, write_register, write_data, read_register,
             debug_addr, clear_start,
      input  read_data, debug_data, clear_busy, clear_done
   );

   modport slave (
      input  RegWrite, write_register, write_data, read_register,
             debug_addr, clear_start,
      output read_data, debug_data, clear_busy, clear_done
   );
endinterface

// File: rtl/regfile_multiport.sv
// Parametrised MIPS register file: N registered read ports, write-to-read
// bypass, optional hardwired r0, one-entry-per-cycle clear engine, debug read.
module regfile_multiport #(
   parameter int WIDTH    = 32,
   parameter int DEPTH    = 32,
   parameter int NB       = $clog2(DEPTH),
   parameter int NUM_RD   = 2,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input logic                clk,
   input logic                reset,
   regfile_multiport_if.slave bus
);

   typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

   localparam logic [NB-1:0] LAST = NB'(DEPTH - 1);

   state_t                  state_q, state_d;
   logic [NB-1:0]           cnt_q, cnt_d;
   logic [WIDTH-1:0]        mem [DEPTH];
   logic                    ew_en;
   logic [NB-1:0]           ew_addr;
   logic [WIDTH-1:0]        ew_data;
   logic [NUM_RD*WIDTH-1:0] rd_d, rd_q;

   function automatic logic in_range(input logic [NB-1:0] a);
      return {1'b0, a} < (NB+1)'(DEPTH);
   endfunction

   // Addresses that can never hold data (r0 when hardwired, beyond DEPTH) read as 0.
   function automatic logic [WIDTH-1:0] array_read(input logic [NB-1:0] a);
      if ((ZERO_REG != 0 && a == '0) || !in_range(a))
         return '0;
      return mem[a];
   endfunction

   // NOTE: every variable written in a combinational block gets a default
   // first, so no path through it can leave a latch behind.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (bus.clear_start) begin
               state_d = CLEAR;
               cnt_d   = '0;
            end
         end
         CLEAR: begin
            if (cnt_q == LAST) state_d = DONE;
            else               cnt_d   = cnt_q + 1'b1;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // The sweep owns the write port while it runs; the WB write is dropped.
   always_comb begin
      ew_addr = bus.write_register;
      ew_data = bus.write_data;
      ew_en   = bus.RegWrite;
      if (state_q == CLEAR) begin
         ew_addr = cnt_q;
         ew_data = '0;
         ew_en   = 1'b1;
      end
      if ((ZERO_REG != 0 && ew_addr == '0) || !in_range(ew_addr))
         ew_en = 1'b0;
   end

   // ew_en is already false for r0 and out-of-range targets, so bypass never
   // forwards into an address that must read 0.
   always_comb begin
      rd_d = '0;
      for (int k = 0; k < NUM_RD; k++) begin
         if (BYPASS != 0 && ew_en && ew_addr == bus.read_register[k*NB +: NB])
            rd_d[k*WIDTH +: WIDTH] = ew_data;
         else
            rd_d[k*WIDTH +: WIDTH] = array_read(bus.read_register[k*NB +: NB]);
      end
   end

   // NOTE: state is updated with non-blocking assignments so every flop in
   // this block samples the values present before the edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rd_q    <= '0;
         // NOTE: the array must read 0 straight after reset, so it is reset
         // entry by entry; this keeps it in flops rather than a RAM macro.
         for (int i = 0; i < DEPTH; i++)
            mem[i] <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rd_q    <= rd_d;
         if (ew_en)
            mem[ew_addr] <= ew_data;
      end
   end

   always_comb begin
      bus.debug_data = array_read(bus.debug_addr);
   end

   assign bus.read_data  = rd_q;
   assign bus.clear_busy = (state_q == CLEAR);
   assign bus.clear_done = (state_q == DONE);

endmodule

// File: tb/tb_regfile_multiport.sv
// Self-checking bench: directed scenarios plus random traffic against an
// array-based reference model, run on a bypassing and a non-bypassing DUT.
module tb_regfile_multiport;
   localparam int WIDTH  = 32;
   localparam int DEPTH  = 32;
   localparam int NB     = 5;
   localparam int NUM_RD = 2;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   regfile_multiport_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NB(NB), .NUM_RD(NUM_RD)) bus ();
   regfile_multiport_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NB(NB), .NUM_RD(NUM_RD)) bus_nb ();

   assign bus_nb.RegWrite       = bus.RegWrite;
   assign bus_nb.write_register = bus.write_register;
   assign bus_nb.write_data     = bus.write_data;
   assign bus_nb.read_register  = bus.read_register;
   assign bus_nb.debug_addr     = bus.debug_addr;
   assign bus_nb.clear_start    = bus.clear_start;

   regfile_multiport #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NB(NB), .NUM_RD(NUM_RD),
                       .ZERO_REG(1), .BYPASS(1))
      dut (.clk(clk), .reset(reset), .bus(bus));

   regfile_multiport #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NB(NB), .NUM_RD(NUM_RD),
                       .ZERO_REG(1), .BYPASS(0))
      dut_nb (.clk(clk), .reset(reset), .bus(bus_nb));

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: plain array plus sweep position (-1 idle, 0..DEPTH-1
   // entry being cleared, DEPTH = completion cycle).
   logic [31:0] mem_m [DEPTH];
   int          sweep       = -1;
   bit          model_valid = 1'b0;
   int          busy_cycles;
   int          done_pulses;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model_read(input int a);
      if (a == 0 || a >= DEPTH) return 32'h0;
      return mem_m[a];
   endfunction

   task automatic set_in(input bit we, input int wa, input logic [31:0] wd,
                         input int ra0, input int ra1);
      bus.RegWrite       = we;
      bus.write_register = NB'(wa);
      bus.write_data     = wd;
      bus.read_register  = {NB'(ra1), NB'(ra0)};
   endtask

   // One clock: check debug before the edge, advance the model, check after.
   task automatic step();
      int          ew_addr;
      logic [31:0] ew_data;
      bit          ew_en;
      logic [31:0] exp_b [NUM_RD];
      logic [31:0] exp_n [NUM_RD];
      #1;
      if (model_valid) begin
         check("debug", bus.debug_data, model_read(int'(bus.debug_addr)));
         check("debug_nb", bus_nb.debug_data, model_read(int'(bus.debug_addr)));
      end
      if (reset) begin
         foreach (mem_m[i]) mem_m[i] = 32'h0;
         for (int k = 0; k < NUM_RD; k++) begin
            exp_b[k] = 32'h0;
            exp_n[k] = 32'h0;
         end
         sweep = -1;
      end else begin
         if (sweep >= 0 && sweep < DEPTH) begin
            ew_addr = sweep;
            ew_data = 32'h0;
            ew_en   = 1'b1;
         end else begin
            ew_addr = int'(bus.write_register);
            ew_data = bus.write_data;
            ew_en   = bus.RegWrite;
         end
         if (ew_addr == 0 || ew_addr >= DEPTH) ew_en = 1'b0;
         for (int k = 0; k < NUM_RD; k++) begin
            int a;
            a        = int'(bus.read_register[k*NB +: NB]);
            exp_n[k] = model_read(a);
            exp_b[k] = (ew_en && ew_addr == a) ? ew_data : exp_n[k];
         end
         if (ew_en) mem_m[ew_addr] = ew_data;
         if (sweep == -1)         sweep = bus.clear_start ? 0 : -1;
         else if (sweep == DEPTH) sweep = -1;
         else                     sweep = sweep + 1;
      end
      model_valid = 1'b1;
      @(posedge clk);
      #1;
      for (int k = 0; k < NUM_RD; k++) begin
         check($sformatf("rd%0d_byp", k), bus.read_data[k*WIDTH +: WIDTH], exp_b[k]);
         check($sformatf("rd%0d_nobyp", k), bus_nb.read_data[k*WIDTH +: WIDTH], exp_n[k]);
      end
      check("busy", 32'(bus.clear_busy), 32'(sweep >= 0 && sweep < DEPTH));
      check("done", 32'(bus.clear_done), 32'(sweep == DEPTH));
      check("busy_nb", 32'(bus_nb.clear_busy), 32'(sweep >= 0 && sweep < DEPTH));
      check("done_nb", 32'(bus_nb.clear_done), 32'(sweep == DEPTH));
      if (bus.clear_busy) busy_cycles++;
      if (bus.clear_done) done_pulses++;
   endtask

   // Full sweep, optionally with WB writes to r3 and a repeated start mid-sweep.
   task automatic run_sweep(input string tag, input bit wb_noise);
      busy_cycles     = 0;
      done_pulses     = 0;
      set_in(0, 0, 32'h0, 1, 2);
      bus.clear_start = 1'b1;
      step();
      bus.clear_start = 1'b0;
      for (int c = 0; c < 100 && done_pulses == 0; c++) begin
         if (wb_noise) set_in(1, 3, 32'hAA, c % DEPTH, 3);
         bus.clear_start = (c == 15);
         step();
      end
      set_in(0, 0, 32'h0, 3, 0);
      bus.clear_start = 1'b0;
      repeat (3) step();
      check({tag, "_busy_cycles"}, busy_cycles, 32);
      check({tag, "_done_pulses"}, done_pulses, 1);
   endtask

   task automatic check_all_zero(input string tag);
      for (int a = 0; a < DEPTH; a++) begin
         set_in(0, 0, 32'h0, a, (a + 1) % DEPTH);
         bus.debug_addr = NB'(a);
         step();
         check(tag, bus.debug_data, 32'h0);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation still running, expected to finish");
      $fatal(1);
   end

   initial begin
      reset           = 1'b1;
      bus.clear_start = 1'b0;
      bus.debug_addr  = '0;
      set_in(0, 0, 32'h0, 5, 7);

      // Reset then read
      step();
      step();
      check("reset_rd0", bus.read_data[31:0], 32'h0);
      reset = 1'b0;
      step();
      check("post_reset_rd1", bus.read_data[63:32], 32'h0);
      check_all_zero("reset_dbg");

      // Write/read latency
      set_in(1, 5, 32'hDEADBEEF, 0, 0);
      step();
      set_in(0, 0, 32'h0, 5, 0);
      bus.debug_addr = NB'(5);
      step();
      check("lat_dbg", bus.debug_data, 32'hDEADBEEF);
      check("lat_rd0", bus.read_data[31:0], 32'hDEADBEEF);

      // Bypass
      set_in(1, 9, 32'h1, 0, 0);
      step();
      set_in(1, 9, 32'h12345678, 9, 9);
      step();
      check("byp_p0", bus.read_data[31:0], 32'h12345678);
      check("byp_p1", bus.read_data[63:32], 32'h12345678);
      check("nobyp_p0", bus_nb.read_data[31:0], 32'h1);
      check("nobyp_p1", bus_nb.read_data[63:32], 32'h1);
      set_in(0, 0, 32'h0, 9, 9);
      step();

      // Zero register
      set_in(1, 0, 32'hFFFFFFFF, 0, 0);
      bus.debug_addr = '0;
      step();
      check("zero_byp_p0", bus.read_data[31:0], 32'h0);
      check("zero_byp_p1", bus.read_data[63:32], 32'h0);
      set_in(0, 0, 32'h0, 0, 0);
      step();
      check("zero_dbg", bus.debug_data, 32'h0);
      check("zero_rd0", bus.read_data[31:0], 32'h0);

      // Random traffic, with occasional sweeps and resets
      for (int i = 0; i < 400; i++) begin
         set_in(1'($urandom_range(0, 1)), $urandom_range(0, DEPTH - 1), $urandom,
                $urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH - 1));
         bus.debug_addr  = NB'($urandom_range(0, DEPTH - 1));
         bus.clear_start = ($urandom_range(0, 63) == 0);
         reset           = ($urandom_range(0, 255) == 0);
         step();
      end
      reset           = 1'b0;
      bus.clear_start = 1'b0;
      set_in(0, 0, 32'h0, 0, 0);
      for (int i = 0; i < 40 && sweep != -1; i++) step();

      // Clear sweep with dropped WB write and ignored restart
      for (int i = 1; i < DEPTH; i++) begin
         set_in(1, i, 32'(i), 0, 0);
         step();
      end
      run_sweep("sweep", 1'b1);
      check_all_zero("sweep_dbg");

      // Reset mid-sweep at counter 10
      for (int i = 1; i < DEPTH; i++) begin
         set_in(1, i, ~32'(i), i, 0);
         step();
      end
      set_in(0, 0, 32'h0, 4, 12);
      bus.clear_start = 1'b1;
      step();
      bus.clear_start = 1'b0;
      repeat (10) step();
      busy_cycles = 0;
      done_pulses = 0;
      reset       = 1'b1;
      step();
      check("midrst_busy", 32'(bus.clear_busy), 32'h0);
      check("midrst_done", 32'(bus.clear_done), 32'h0);
      reset = 1'b0;
      repeat (3) step();
      check("midrst_no_done", done_pulses, 0);
      check_all_zero("midrst_dbg");
      run_sweep("resweep", 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/regfile_multiport.md
Name: regfile_multiport

Overview:
- Parametrised MIPS general-purpose register file. Successor to the current 2-read/1-write file.
- Adds a configurable number of read ports, write-to-read bypass and an optional hardwired zero register.
- Adds a sequenced clear engine that zeroes the array one entry per cycle, and a combinational debug read port for the UART/debug unit.
- Sits in the ID stage. The WB stage drives the write port.

Parameters:
- WIDTH, 32, data width in bits.
- DEPTH, 32, number of registers.
- NB, $clog2(DEPTH), register address width.
- NUM_RD, 2, number of registered read ports (1..4).
- ZERO_REG, 1, when 1 register 0 always reads 0 and writes to it are discarded.
- BYPASS, 1, when 1 a same-cycle write to a register being read is forwarded to that read output.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- RegWrite  in  1  write enable from WB.
- write_register  in  NB  write address.
- write_data  in  WIDTH  write data.
- read_register  in  NUM_RD*NB  read addresses; port k occupies bits [k*NB +: NB].
- read_data  out  NUM_RD*WIDTH  registered read data; port k occupies bits [k*WIDTH +: WIDTH].
- debug_addr  in  NB  debug read address.
- debug_data  out  WIDTH  combinational debug read of the array.
- clear_start  in  1  request a full-array clear sweep.
- clear_busy  out  1  high while the sweep is running.
- clear_done  out  1  one-cycle pulse when the sweep completes.

Behaviour:
- Clock and reset:
  - One clock, clk. Reset is synchronous and active-high, named reset.
  - All writes happen on posedge only; there are no negedge writes.
- Reset, at the posedge with reset=1:
  - Every array entry becomes 0.
  - read_data becomes 0.
  - FSM goes to IDLE, clear_busy=0, clear_done=0, clear counter=0.
  - reset overrides every other input in that cycle, including a sweep in progress.
- Effective write (ew) each cycle:
  - In CLEAR: address = counter, data = 0, enable = 1. RegWrite is ignored and the WB write is dropped; the WB stage must not write while clear_busy is high.
  - Otherwise: address = write_register, data = write_data, enable = RegWrite.
  - If ZERO_REG=1 and the ew address is 0, the enable is forced to 0.
- Read ports:
  - Latency is 1 cycle: read_data[k] at posedge n+1 reflects read_register[k] sampled at posedge n.
  - BYPASS=1 and ew enabled and ew address == read_register[k]: read_data[k] <= ew data.
  - Otherwise read_data[k] <= array[read_register[k]], meaning the old contents.
  - ZERO_REG=1 and read_register[k]==0: read_data[k] <= 0 regardless of any other condition.
- debug_data = array[debug_addr], purely combinational. It shows the contents before that cycle's write. It reads 0 for address 0 when ZERO_REG=1.
- Clear FSM:
  - IDLE: clear_start=1 → CLEAR, counter=0, clear_busy=1 from the next cycle.
  - CLEAR: writes 0 to entry counter, then counter+1. When counter==DEPTH-1 → DONE.
  - DONE: clear_done=1 for exactly one cycle, clear_busy=0 → IDLE.
  - clear_start is ignored while in CLEAR or DONE; there is no restart mid-sweep.
  - A sweep takes exactly DEPTH cycles with clear_busy high.
  - Reads remain serviced during a sweep. Bypass applies to clear writes, so a read of the entry being cleared returns 0.
- Widths and indexing:
  - DEPTH need not be a power of 2.
  - A write or read address >= DEPTH is out of range: the write is discarded and the read returns 0.
  - The counter is NB bits wide and never wraps past DEPTH-1.

Test Plan:
- Reset then read:
  - Stimulus: reset 2 cycles, then read_register={5,7}.
  - Required: read_data=0 during reset; {0,0} one cycle after the addresses are applied; debug_data=0 for all 32 addresses.
- Write/read latency:
  - Stimulus: write r5=0xDEADBEEF (RegWrite=1) at cycle n; read r5 on port 0 at cycle n+1.
  - Required: read_data[0]=0xDEADBEEF at posedge n+2; debug_data(5)=0xDEADBEEF after posedge n+1.
- Bypass:
  - Stimulus: same cycle, write r9=0x12345678 while both ports read r9; r9 previously 0x1.
  - Required with BYPASS=1: both ports 0x12345678 next cycle.
  - Required with BYPASS=0: both ports 0x1 next cycle.
- Zero register:
  - Stimulus: write r0=0xFFFFFFFF, then read r0 on all ports and via debug.
  - Required: all reads return 0 and no bypass occurs (ZERO_REG=1).
- Clear sweep:
  - Stimulus: fill r1..r31 with their index, pulse clear_start, and assert RegWrite r3=0xAA during the sweep.
  - Required: clear_busy high exactly 32 cycles; clear_done one pulse; every entry reads 0 afterwards (the 0xAA write is dropped); a second clear_start mid-sweep has no effect.
- Reset mid-sweep:
  - Stimulus: assert reset at counter=10.
  - Required: next cycle clear_busy=0, no clear_done pulse, all entries 0, FSM in IDLE; a new clear_start then runs a full 32-cycle sweep.
